// File: rtl/ahb_fill_master_if.sv
// Command port and AHB-Lite master signals of the fill engine, bundled with
// master (engine side) and slave (bus/command side) views.
interface ahb_fill_master_if #(
    parameter int LEN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      cmd_data;
    logic             done;
    logic             err;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic             HRESP;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_data, HREADY, HRESP,
        output cmd_ready, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_data, HREADY, HRESP,
        input  cmd_ready, done, err, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_fill_master.sv
// AHB-Lite master filling a word-aligned region with INCR word writes.
// Define FILL_INCR_DATA_EN to write a ramp (cmd_data + beat index) instead of a constant.
module ahb_fill_master #(
    parameter int LEN_W    = 16,
    parameter int BOUNDARY = 1024
) (
    input  logic HCLK,
    input  logic HRESET,
    ahb_fill_master_if.master bus
);
    localparam int          OFF_W  = $clog2(BOUNDARY);
    localparam logic [1:0]  T_IDLE = 2'b00;
    localparam logic [1:0]  T_NSEQ = 2'b10;
    localparam logic [1:0]  T_SEQ  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_LAST, S_FIN} state_t;

    state_t           state, state_nxt;
    logic [31:0]      haddr_q;
    logic [31:0]      hwdata_q;
    logic [31:0]      beat_data;
    logic [31:0]      beat_data_nxt;
    logic [LEN_W-1:0] cnt;
    logic             err_q;
    logic [1:0]       htrans;
    logic             abort;
    logic             at_boundary;
    logic             accept;

`ifdef FILL_INCR_DATA_EN
    assign beat_data_nxt = beat_data + 32'd1;
`else
    assign beat_data_nxt = beat_data;
`endif

    // An error response seen in an earlier cycle keeps the transfer aborted.
    assign abort       = err_q | bus.HRESP;
    assign at_boundary = (haddr_q[OFF_W-1:0] == '0);
    // Address phase of the beat currently on HADDR completes this cycle.
    assign accept      = bus.HREADY & ((state == S_ADDR) | ((state == S_PIPE) & ~abort));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        htrans    = T_IDLE;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid)
                    state_nxt = (bus.cmd_len == '0) ? S_FIN : S_ADDR;
            end
            S_ADDR: begin
                htrans = T_NSEQ;
                if (bus.HREADY)
                    state_nxt = (cnt == LEN_W'(1)) ? S_LAST : S_PIPE;
            end
            S_PIPE: begin
                if (abort) begin
                    if (bus.HREADY) state_nxt = S_FIN;
                end else begin
                    htrans = at_boundary ? T_NSEQ : T_SEQ;
                    if (bus.HREADY && cnt == LEN_W'(1)) state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                if (bus.HREADY) state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            haddr_q   <= 32'd0;
            hwdata_q  <= 32'd0;
            beat_data <= 32'd0;
            cnt       <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.cmd_valid) begin
                haddr_q   <= bus.cmd_addr & ~32'h3;
                beat_data <= bus.cmd_data;
                cnt       <= bus.cmd_len;
                err_q     <= 1'b0;
            end
            // Data phase of the accepted beat starts next cycle.
            if (accept) begin
                hwdata_q  <= beat_data;
                beat_data <= beat_data_nxt;
                cnt       <= cnt - LEN_W'(1);
                if (cnt != LEN_W'(1)) haddr_q <= haddr_q + 32'd4;
            end
            if ((state == S_PIPE || state == S_LAST) && bus.HRESP)
                err_q <= 1'b1;
        end
    end

    assign bus.HTRANS    = htrans;
    assign bus.HWRITE    = htrans[1];
    assign bus.HSIZE     = 3'b010;
    assign bus.HBURST    = 3'b001;
    assign bus.HADDR     = haddr_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.done      = (state == S_FIN);
    assign bus.err       = (state == S_FIN) & err_q;
endmodule

// File: tb/tb_ahb_fill_master.sv
// Directed bench for ahb_fill_master: per-cycle bus expectations written out by hand.
module tb_ahb_fill_master;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;

    ahb_fill_master_if #(.LEN_W(16)) bus ();

    ahb_fill_master #(.LEN_W(16), .BOUNDARY(1024)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; drives slave response, checks mid-cycle.
    task automatic cyc(string tag, bit rdy, bit rsp, logic [1:0] tr,
                       logic [31:0] ad, bit ck_ad, logic [31:0] wd, bit ck_wd,
                       bit dn, bit er);
        bus.HREADY = rdy;
        bus.HRESP  = rsp;
        #3;
        check({tag, ".htrans"}, 32'(bus.HTRANS), 32'(tr));
        check({tag, ".done"}, 32'(bus.done), 32'(dn));
        check({tag, ".err"}, 32'(bus.err), 32'(er));
        if (ck_ad) check({tag, ".haddr"}, bus.HADDR, ad);
        if (ck_wd) check({tag, ".hwdata"}, bus.HWDATA, wd);
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(logic [31:0] a, logic [15:0] l, logic [31:0] d);
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_data  = d;
        #3;
        check("accept.ready", 32'(bus.cmd_ready), 32'd1);
        check("accept.htrans", 32'(bus.HTRANS), 32'(ID));
        @(posedge HCLK);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    logic [31:0] d1, d2;

    initial begin
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'd0;
        bus.cmd_len   = 16'd0;
        bus.cmd_data  = 32'd0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        #12;
        check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.err", 32'(bus.err), 32'd0);
        check("rst.haddr", bus.HADDR, 32'd0);
        check("rst.htrans", 32'(bus.HTRANS), 32'(ID));
        check("rst.hwrite", 32'(bus.HWRITE), 32'd0);
        check("rst.hwdata", bus.HWDATA, 32'd0);
        check("rst.hsize", 32'(bus.HSIZE), 32'd2);
        check("rst.hburst", 32'(bus.HBURST), 32'd1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        cyc("idle", 1, 0, ID, 32'd0, 1, 32'd0, 1, 0, 0);

        // 1: basic burst, cmd_valid with other fields held high while busy
        issue(32'h5000_0000, 16'd4, 32'h0000_00A5);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0000_1234;
        bus.cmd_len   = 16'd1;
        bus.cmd_data  = 32'hDEAD_BEEF;
        cyc("t1.b0", 1, 0, NS, 32'h5000_0000, 1, 0, 0, 0, 0);
        check("t1.busy.ready", 32'(bus.cmd_ready), 32'd0);
        check("t1.hwrite", 32'(bus.HWRITE), 32'd1);
        cyc("t1.b1", 1, 0, SQ, 32'h5000_0004, 1, 32'hA5, 1, 0, 0);
        cyc("t1.b2", 1, 0, SQ, 32'h5000_0008, 1, 32'hA5, 1, 0, 0);
        cyc("t1.b3", 1, 0, SQ, 32'h5000_000C, 1, 32'hA5, 1, 0, 0);
        bus.cmd_valid = 1'b0;
        cyc("t1.last", 1, 0, ID, 0, 0, 32'hA5, 1, 0, 0);
        check("t1.fin.ready", 32'(bus.cmd_ready), 32'd0);
        cyc("t1.fin", 1, 0, ID, 0, 0, 32'hA5, 1, 1, 0);
        check("t1.idle.ready", 32'(bus.cmd_ready), 32'd1);
        cyc("t1.idle", 1, 0, ID, 0, 0, 0, 0, 0, 0);

        // 2: three wait states in the data phase of beat 2
        issue(32'h5000_0000, 16'd4, 32'h0000_00A5);
        cyc("t2.b0", 1, 0, NS, 32'h5000_0000, 1, 0, 0, 0, 0);
        cyc("t2.b1", 1, 0, SQ, 32'h5000_0004, 1, 32'hA5, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("t2.wait", 0, 0, SQ, 32'h5000_0008, 1, 32'hA5, 1, 0, 0);
        cyc("t2.b2", 1, 0, SQ, 32'h5000_0008, 1, 32'hA5, 1, 0, 0);
        cyc("t2.b3", 1, 0, SQ, 32'h5000_000C, 1, 32'hA5, 1, 0, 0);
        cyc("t2.last", 1, 0, ID, 0, 0, 32'hA5, 1, 0, 0);
        cyc("t2.fin", 1, 0, ID, 0, 0, 0, 0, 1, 0);
        cyc("t2.idle", 1, 0, ID, 0, 0, 0, 0, 0, 0);

        // 3: burst crosses a 1 KiB boundary
        issue(32'h5000_03F8, 16'd4, 32'h1234_5678);
        cyc("t3.b0", 1, 0, NS, 32'h5000_03F8, 1, 0, 0, 0, 0);
        cyc("t3.b1", 1, 0, SQ, 32'h5000_03FC, 1, 32'h1234_5678, 1, 0, 0);
        cyc("t3.b2", 1, 0, NS, 32'h5000_0400, 1, 32'h1234_5678, 1, 0, 0);
        cyc("t3.b3", 1, 0, SQ, 32'h5000_0404, 1, 32'h1234_5678, 1, 0, 0);
        cyc("t3.last", 1, 0, ID, 0, 0, 32'h1234_5678, 1, 0, 0);
        cyc("t3.fin", 1, 0, ID, 0, 0, 0, 0, 1, 0);
        cyc("t3.idle", 1, 0, ID, 0, 0, 0, 0, 0, 0);

        // 4: ERROR on beat 2 aborts the rest
        issue(32'h5000_0000, 16'd4, 32'h0000_00A5);
        cyc("t4.b0", 1, 0, NS, 32'h5000_0000, 1, 0, 0, 0, 0);
        cyc("t4.b1", 1, 0, SQ, 32'h5000_0004, 1, 32'hA5, 1, 0, 0);
        cyc("t4.err1", 0, 1, ID, 0, 0, 32'hA5, 1, 0, 0);
        cyc("t4.err2", 1, 1, ID, 0, 0, 32'hA5, 1, 0, 0);
        cyc("t4.fin", 1, 0, ID, 0, 0, 0, 0, 1, 1);
        cyc("t4.idle", 1, 0, ID, 0, 0, 0, 0, 0, 0);
        cyc("t4.idle2", 1, 0, ID, 0, 0, 0, 0, 0, 0);

        // 5: zero-length command
        issue(32'h7000_0000, 16'd0, 32'h0000_0055);
        cyc("t5.fin", 1, 0, ID, 0, 0, 0, 0, 1, 0);
        cyc("t5.idle", 1, 0, ID, 0, 0, 0, 0, 0, 0);

        // 5b: asynchronous reset mid-burst
        issue(32'h6000_0000, 16'd8, 32'h0000_0077);
        cyc("rb.b0", 1, 0, NS, 32'h6000_0000, 1, 0, 0, 0, 0);
        cyc("rb.b1", 1, 0, SQ, 32'h6000_0004, 1, 32'h77, 1, 0, 0);
        #2;
        HRESET = 1'b1;
        #1;
        check("rb.htrans", 32'(bus.HTRANS), 32'(ID));
        check("rb.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rb.haddr", bus.HADDR, 32'd0);
        check("rb.hwdata", bus.HWDATA, 32'd0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("rb.after", 1, 0, ID, 32'd0, 1, 32'd0, 1, 0, 0);

        // 6: data pattern (ramp when FILL_INCR_DATA_EN)
`ifdef FILL_INCR_DATA_EN
        d1 = 32'hFFFF_FFFF;
        d2 = 32'h0000_0000;
`else
        d1 = 32'hFFFF_FFFE;
        d2 = 32'hFFFF_FFFE;
`endif
        issue(32'h5000_0100, 16'd3, 32'hFFFF_FFFE);
        cyc("t6.b0", 1, 0, NS, 32'h5000_0100, 1, 0, 0, 0, 0);
        cyc("t6.b1", 1, 0, SQ, 32'h5000_0104, 1, 32'hFFFF_FFFE, 1, 0, 0);
        cyc("t6.b2", 1, 0, SQ, 32'h5000_0108, 1, d1, 1, 0, 0);
        cyc("t6.last", 1, 0, ID, 0, 0, d2, 1, 0, 0);
        cyc("t6.fin", 1, 0, ID, 0, 0, 0, 0, 1, 0);

        // 7: address wrap at top of memory, misaligned base bits ignored
        issue(32'hFFFF_FFFB, 16'd3, 32'h0000_0011);
        cyc("t7.b0", 1, 0, NS, 32'hFFFF_FFF8, 1, 0, 0, 0, 0);
        cyc("t7.b1", 1, 0, SQ, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        cyc("t7.b2", 1, 0, NS, 32'h0000_0000, 1, 0, 0, 0, 0);
        cyc("t7.last", 1, 0, ID, 0, 0, 0, 0, 0, 0);
        cyc("t7.fin", 1, 0, ID, 0, 0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
